timer_arbiter: RTL and testbench

- Round-robin scheduler that shares one down-counting interval timer between NREQ requesters.
- Each requester asks for a delay of len ticks (ticks come from an external prescaler).
- The block grants the timer to one requester, loads the requested length and counts it down on ticks.
- It then pulses that requester's done and moves to the next requester.
- Sits between the trigger/sequencing logic and the shared timer resource in the FPGA fabric.

---
 rtl/timer_arbiter.sv | 129 ++++++++++++
 tb/tb_timer_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// Round-robin owner of one shared down-counting interval timer.
// Grants NREQ requesters in turn, counts len ticks, pulses done.
module timer_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  tick,
    input  logic                  clear,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [NREQ-1:0]       done,
    output logic                  aborted,
    output logic [WIDTH-1:0]      remaining
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COUNT,
        DONE
    } state_t;

    state_t            state;
    logic [IW-1:0]     sel;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     pick;
    logic [NREQ-1:0]   pick_oh;
    logic [NREQ-1:0]   sel_oh;
    logic [WIDTH-1:0]  sel_len;
    logic              found;
    logic              stop;

    // Search starts just past the last served requester.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        pick_oh = '0;
        sel_oh  = '0;
        sel_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            pick_oh[i] = (IW'(i) == pick);
            sel_oh[i]  = (IW'(i) == sel);
            if (IW'(i) == sel) begin
                sel_len = len[i*WIDTH +: WIDTH];
            end
        end
    end

    assign stop = clear || !(|(req & sel_oh));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            sel       <= '0;
            ptr       <= IW'(NREQ - 1);
            grant     <= '0;
            busy      <= 1'b0;
            done      <= '0;
            aborted   <= 1'b0;
            remaining <= '0;
        end else begin
            done    <= '0;
            aborted <= 1'b0;
            if ((state == LOAD || state == COUNT) && stop) begin
                // Abort beats a coincident terminal tick.
                state     <= IDLE;
                grant     <= '0;
                busy      <= 1'b0;
                remaining <= '0;
                aborted   <= 1'b1;
                ptr       <= sel;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (found) begin
                            sel   <= pick;
                            grant <= pick_oh;
                            busy  <= 1'b1;
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        remaining <= sel_len;
                        if (sel_len == '0) begin
                            done  <= sel_oh;
                            state <= DONE;
                        end else begin
                            state <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (tick && remaining != '0) begin
                            remaining <= remaining - WIDTH'(1);
                            if (remaining == WIDTH'(1)) begin
                                done  <= sel_oh;
                                state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= sel;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Scenario bench for timer_arbiter with a done/aborted scoreboard.
// Each task drives one feature; a monitor pops expected pulse events.
module tb_timer_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk;
    logic           rstn;
    logic           tick;
    logic           clear;
    logic [N-1:0]   req;
    logic [N*W-1:0] len;
    logic [N-1:0]   grant;
    logic           busy;
    logic [N-1:0]   done;
    logic           aborted;
    logic [W-1:0]   remaining;

    typedef struct packed {
        logic [N-1:0] d;
        logic         a;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  checks;
    int  passes;

    timer_arbiter #(.NREQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .tick      (tick),
        .clear     (clear),
        .req       (req),
        .len       (len),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstn) begin
            checks++;
            if ($countones(grant) > 1 || (done & ~grant) != 0 ||
                (done != 0 && aborted))
                $display("FAIL invariant grant=%b done=%b aborted=%b",
                         grant, done, aborted);
            else
                passes++;
            if (done != 0 || aborted) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL event_unexpected done=%b aborted=%b",
                             done, aborted);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({done, aborted} !== mon_e)
                        $display("FAIL event got done=%b ab=%b want done=%b ab=%b",
                                 done, aborted, mon_e.d, mon_e.a);
                    else
                        passes++;
                end
            end
        end
    end

    task automatic set_len(input int i, input int v);
        len[i*W +: W] = W'(v);
    endtask

    task automatic push_ev(input logic [N-1:0] d, input logic a);
        ev_t e;
        e.d = d;
        e.a = a;
        exp_q.push_back(e);
    endtask

    task automatic wait_rem(input logic [W-1:0] v, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (remaining == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, busy, done, aborted, remaining} !== '0)
            $display("FAIL reset_outputs got g=%b b=%b d=%b a=%b r=%0d want all 0",
                     grant, busy, done, aborted, remaining);
        else
            passes++;
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || grant !== '0)
            $display("FAIL reset_idle got busy=%b grant=%b want 0 0", busy, grant);
        else
            passes++;
    endtask

    task automatic test_round_robin();
        int           order[5] = '{0, 1, 2, 3, 0};
        int           ng = 0;
        int           nd = 0;
        logic [N-1:0] prev = '0;
        for (int i = 0; i < N; i++) set_len(i, 2);
        for (int k = 0; k < 5; k++) push_ev(N'(1 << order[k]), 1'b0);
        req = 4'b1111;
        for (int c = 0; c < 400 && nd < 5; c++) begin
            tick = (c % 4 == 3);
            @(negedge clk);
            if (grant != 0 && prev == 0) begin
                checks++;
                if (ng < 5 && grant === N'(1 << order[ng]))
                    passes++;
                else
                    $display("FAIL rr_grant #%0d got %b want %b", ng, grant,
                             N'(1 << order[ng % 5]));
                ng++;
            end
            prev = grant;
            if (done != 0) begin
                nd++;
                if (nd == 5) req = '0;
            end
        end
        tick = 1'b0;
        checks++;
        if (nd != 5 || ng != 5)
            $display("FAIL rr_count got dones=%0d grants=%0d want 5 5", nd, ng);
        else
            passes++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0)
            $display("FAIL rr_idle got busy=%b want 0", busy);
        else
            passes++;
    endtask

    task automatic test_single();
        set_len(0, 3);
        req  = 4'b0001;
        tick = 1'b1;
        push_ev(4'b0001, 1'b0);
        @(negedge clk);
        checks++;
        if (grant !== 4'b0001 || busy !== 1'b1)
            $display("FAIL single_grant got g=%b b=%b want 0001 1", grant, busy);
        else
            passes++;
        for (int v = 3; v >= 0; v--) begin
            @(negedge clk);
            checks++;
            if (remaining !== W'(v))
                $display("FAIL single_rem got %0d want %0d", remaining, v);
            else
                passes++;
        end
        checks++;
        if (done !== 4'b0001)
            $display("FAIL single_done got %b want 0001", done);
        else
            passes++;
        req  = '0;
        tick = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || grant !== '0 || remaining !== '0)
            $display("FAIL single_after got b=%b g=%b r=%0d want 0 0 0",
                     busy, grant, remaining);
        else
            passes++;
    endtask

    task automatic test_zero();
        set_len(2, 0);
        req  = 4'b0100;
        tick = 1'b0;
        push_ev(4'b0100, 1'b0);
        @(negedge clk);
        checks++;
        if (grant !== 4'b0100)
            $display("FAIL zero_grant got %b want 0100", grant);
        else
            passes++;
        @(negedge clk);
        checks++;
        if (done !== 4'b0100 || remaining !== '0)
            $display("FAIL zero_done got d=%b r=%0d want 0100 0", done, remaining);
        else
            passes++;
        req = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0)
            $display("FAIL zero_idle got busy=%b want 0", busy);
        else
            passes++;
    endtask

    task automatic test_abort_clear();
        bit ok;
        set_len(1, 10);
        req  = 4'b0010;
        tick = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0010)
            $display("FAIL clr_grant got %b want 0010", grant);
        else
            passes++;
        req = 4'b0110;
        wait_rem(W'(6), ok);
        checks++;
        if (!ok)
            $display("FAIL clr_wait got remaining=%0d want 6", remaining);
        else
            passes++;
        clear = 1'b1;
        push_ev('0, 1'b1);
        @(negedge clk);
        checks++;
        if (aborted !== 1'b1 || remaining !== '0 || grant !== '0 || busy !== 1'b0)
            $display("FAIL clr_abort got a=%b r=%0d g=%b b=%b want 1 0 0 0",
                     aborted, remaining, grant, busy);
        else
            passes++;
        clear = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0100)
            $display("FAIL clr_next got %b want 0100", grant);
        else
            passes++;
        req = '0;
        push_ev('0, 1'b1);
        @(negedge clk);
        checks++;
        if (aborted !== 1'b1 || grant !== '0)
            $display("FAIL load_abort got a=%b g=%b want 1 0", aborted, grant);
        else
            passes++;
        tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort_drop();
        bit ok;
        set_len(0, 9);
        req  = 4'b0001;
        tick = 1'b1;
        @(negedge clk);
        wait_rem(W'(5), ok);
        checks++;
        if (!ok)
            $display("FAIL drop_wait got remaining=%0d want 5", remaining);
        else
            passes++;
        req = '0;
        push_ev('0, 1'b1);
        @(negedge clk);
        checks++;
        if (aborted !== 1'b1 || remaining !== '0 || grant !== '0)
            $display("FAIL drop_abort got a=%b r=%0d g=%b want 1 0 0",
                     aborted, remaining, grant);
        else
            passes++;
        tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_race();
        bit ok;
        set_len(2, 3);
        req  = 4'b0100;
        tick = 1'b1;
        @(negedge clk);
        wait_rem(W'(1), ok);
        checks++;
        if (!ok)
            $display("FAIL race_wait got remaining=%0d want 1", remaining);
        else
            passes++;
        clear = 1'b1;
        push_ev('0, 1'b1);
        @(negedge clk);
        checks++;
        if (done !== '0 || aborted !== 1'b1 || remaining !== '0)
            $display("FAIL race got d=%b a=%b r=%0d want 0000 1 0",
                     done, aborted, remaining);
        else
            passes++;
        clear = 1'b0;
        req   = '0;
        tick  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit ok;
        set_len(0, 20);
        req  = 4'b0001;
        tick = 1'b1;
        @(negedge clk);
        wait_rem(W'(7), ok);
        checks++;
        if (!ok)
            $display("FAIL arst_wait got remaining=%0d want 7", remaining);
        else
            passes++;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (grant !== '0 || busy !== 1'b0 || remaining !== '0)
            $display("FAIL arst_now got g=%b b=%b r=%0d want 0 0 0",
                     grant, busy, remaining);
        else
            passes++;
        req  = 4'b1001;
        tick = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0001)
            $display("FAIL arst_prio got %b want 0001", grant);
        else
            passes++;
        req = '0;
        push_ev('0, 1'b1);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rstn   = 1'b0;
        tick   = 1'b0;
        clear  = 1'b0;
        req    = '0;
        len    = '0;
        checks = 0;
        passes = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_zero();
        test_abort_clear();
        test_abort_drop();
        test_race();
        test_async_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL pending_events got %0d want 0", exp_q.size());
        else
            passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
